// File: rtl/bcd_alu_pkg.sv
// Shared definitions for the sequential BCD ALU: op codes, FSM states and width helpers.
// The optional signed-subtract feature is enabled by defining BCD_ALU_SIGN_EN.
package bcd_alu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_PASS = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CONV_IN  = 3'd1,
    ST_EXEC     = 3'd2,
    ST_CONV_OUT = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  function automatic int pow10(input int n);
    int p;
    p = 32'sd1;
    for (int i = 0; i < n; i++) p = p * 32'sd10;
    return p;
  endfunction

  // Smallest width holding the largest possible add result, 2*10^DIGITS.
  function automatic int bin_width(input int digits);
    longint lim;
    int     w;
    lim = 64'sd2 * longint'(pow10(digits));
    w   = 32'sd1;
    while ((64'sd1 << w) < lim) w = w + 32'sd1;
    return w;
  endfunction

endpackage

// File: rtl/bcd_dabble_seq.sv
// Iterative double-dabble: binary to packed BCD, one shift per cycle, BIN_W cycles per load.
// done_o flags the cycle in which the final shift is taken; bcd_o is final after that edge.
module bcd_dabble_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [BIN_W-1:0]      bin_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  done_o
);

  localparam int NW    = 4 * DIGITS;
  localparam int SH_W  = NW + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);

  logic [SH_W-1:0]  sh_q;
  logic [SH_W-1:0]  sh_d;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [NW-1:0] add3(input logic [NW-1:0] b);
    logic [NW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++)
      r[4*i +: 4] = (r[4*i +: 4] >= 4'd5) ? (r[4*i +: 4] + 4'd3) : r[4*i +: 4];
    return r;
  endfunction

  // Correct every BCD digit, then shift the whole register left by one.
  always_comb begin
    sh_d = {add3(sh_q[SH_W-1 -: NW]), sh_q[BIN_W-1:0]};
    sh_d = {sh_d[SH_W-2:0], 1'b0};
  end

  // Load a new value or step the conversion while shifts remain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sh_q  <= {{NW{1'b0}}, bin_i};
      cnt_q <= CNT_INIT;
    end else if (cnt_q != '0) begin
      sh_q  <= sh_d;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign bcd_o  = sh_q[SH_W-1 -: NW];
  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/bcd_alu_seq.sv
// Sequential BCD ALU: BCD->binary, add/sub/pass, binary->BCD via double-dabble.
// Define BCD_ALU_SIGN_EN to return |num1-num2| with neg=1 instead of an error.
module bcd_alu_seq
  import bcd_alu_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [4*DIGITS-1:0] num1,
  input  logic [4*DIGITS-1:0] num2,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] res,
  output logic                ovf,
  output logic                neg,
  output logic                err
);

  localparam int NW    = 4 * DIGITS;
  localparam int BIN_W = bin_width(DIGITS);
  localparam int CW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [BIN_W-1:0] LIMIT = BIN_W'(pow10(DIGITS));

  state_e           state_q;
  logic [1:0]       op_q;
  logic [NW-1:0]    n1_q, n2_q, res_q;
  logic [BIN_W-1:0] acc1_q, acc2_q, acc1_d, acc2_d;
  logic [CW-1:0]    dig_cnt_q;
  logic             bad_q, bad_d;
  logic             busy_q, done_q, ovf_q, neg_q, err_q;
  logic             ovf_p_q, neg_p_q, err_p_q;
  logic [3:0]       dig1_s, dig2_s;
  logic [BIN_W-1:0] sum_s, exec_bin_d;
  logic             exec_ovf_d, exec_neg_d, exec_err_d;
  logic             dab_load_s, dab_done_s;
  logic [NW-1:0]    dab_bcd_s;

  // Horner step on the current most significant digit of each operand.
  always_comb begin
    dig1_s = n1_q[NW-1 -: 4];
    dig2_s = n2_q[NW-1 -: 4];
    acc1_d = (acc1_q << 3) + (acc1_q << 1) + BIN_W'(dig1_s);
    acc2_d = (acc2_q << 3) + (acc2_q << 1) + BIN_W'(dig2_s);
    bad_d  = bad_q | (dig1_s > 4'd9) | (dig2_s > 4'd9);
  end

  // Arithmetic performed in the EXEC cycle.
  always_comb begin
    sum_s      = acc1_q + acc2_q;
    exec_bin_d = '0;
    exec_ovf_d = 1'b0;
    exec_neg_d = 1'b0;
    exec_err_d = 1'b0;
    case (op_q)
      OP_ADD: begin
        if (sum_s >= LIMIT) begin
          exec_bin_d = sum_s - LIMIT;
          exec_ovf_d = 1'b1;
        end else begin
          exec_bin_d = sum_s;
        end
      end
      OP_SUB: begin
        if (acc1_q >= acc2_q) begin
          exec_bin_d = acc1_q - acc2_q;
        end else begin
`ifdef BCD_ALU_SIGN_EN
          exec_bin_d = acc2_q - acc1_q;
          exec_neg_d = 1'b1;
`else
          exec_err_d = 1'b1;
`endif
        end
      end
      OP_PASS: exec_bin_d = acc1_q;
      default: exec_err_d = 1'b1;
    endcase
  end

  assign dab_load_s = (state_q == ST_EXEC) && !exec_err_d;

  bcd_dabble_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_dabble (
    .clk    (clk),
    .rst    (rst),
    .load_i (dab_load_s),
    .bin_i  (exec_bin_d),
    .bcd_o  (dab_bcd_s),
    .done_o (dab_done_s)
  );

  // Control FSM with registered outputs; results publish on leaving DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      n1_q      <= '0;
      n2_q      <= '0;
      acc1_q    <= '0;
      acc2_q    <= '0;
      dig_cnt_q <= '0;
      bad_q     <= 1'b0;
      ovf_p_q   <= 1'b0;
      neg_p_q   <= 1'b0;
      err_p_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      neg_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            n1_q      <= num1;
            n2_q      <= num2;
            op_q      <= op;
            acc1_q    <= '0;
            acc2_q    <= '0;
            bad_q     <= 1'b0;
            ovf_p_q   <= 1'b0;
            neg_p_q   <= 1'b0;
            err_p_q   <= 1'b0;
            dig_cnt_q <= CW'(DIGITS - 1);
            busy_q    <= 1'b1;
            state_q   <= ST_CONV_IN;
          end
        end
        ST_CONV_IN: begin
          acc1_q <= acc1_d;
          acc2_q <= acc2_d;
          bad_q  <= bad_d;
          n1_q   <= n1_q << 4;
          n2_q   <= n2_q << 4;
          if (dig_cnt_q == '0) begin
            err_p_q <= bad_d;
            state_q <= bad_d ? ST_DONE : ST_EXEC;
          end else begin
            dig_cnt_q <= dig_cnt_q - CW'(1);
          end
        end
        ST_EXEC: begin
          ovf_p_q <= exec_ovf_d;
          neg_p_q <= exec_neg_d;
          err_p_q <= exec_err_d;
          state_q <= exec_err_d ? ST_DONE : ST_CONV_OUT;
        end
        ST_CONV_OUT: begin
          if (dab_done_s) state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          res_q   <= err_p_q ? '0 : dab_bcd_s;
          ovf_q   <= ovf_p_q & ~err_p_q;
          neg_q   <= neg_p_q & ~err_p_q;
          err_q   <= err_p_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign res  = res_q;
  assign ovf  = ovf_q;
  assign neg  = neg_q;
  assign err  = err_q;

endmodule

// File: doc/bcd_alu_seq.md
BCD_ALU_SEQ -- requirements
Module: bcd_alu_seq

Interface
REQ-001 Parameter DIGITS, default 4, number of packed BCD digits per operand and result; legal range 1..8.
REQ-002 Localparam BIN_W = ceil(log2(2*10^DIGITS)) is the internal binary width (15 for DIGITS=4).
REQ-003 Clock and reset: one clock, and reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  request a new operation; sampled only in IDLE.
REQ-007 op  in  2  operation: 00 add, 01 subtract (num1-num2), 10 pass num1, 11 reserved.
REQ-008 num1  in  4*DIGITS  operand 1, packed BCD, most significant digit in the top nibble.
REQ-009 num2  in  4*DIGITS  operand 2, same format as num1.
REQ-010 busy  out  1  high from the cycle after start is accepted until done.
REQ-011 done  out  1  single-cycle pulse; res/ovf/neg/err are valid while it is high and held until the next accept.
REQ-012 res  out  4*DIGITS  packed BCD result.
REQ-013 ovf  out  1  add result exceeded 10^DIGITS-1.
REQ-014 neg  out  1  result is negative; res holds the magnitude.
REQ-015 err  out  1  invalid BCD input digit, reserved op, or negative result without sign support.

Function
REQ-016 FSM states SHALL be IDLE, CONV_IN, EXEC, CONV_OUT, DONE.
REQ-017 IDLE with start=1 SHALL latch num1, num2 and op, then go to CONV_IN; start outside IDLE SHALL be ignored.
REQ-018 CONV_IN SHALL take DIGITS cycles, one digit of each operand per cycle, MSD first: acc = acc*10 + digit.
REQ-019 Any digit >9 seen in CONV_IN SHALL set err=1, force res=0, and go directly to DONE once CONV_IN completes.
REQ-020 EXEC SHALL take 1 cycle and compute the BIN_W-bit result; op=11 SHALL set err=1, res=0 and go to DONE.
REQ-021 Add results >10^DIGITS-1 SHALL set ovf=1, with res = sum mod 10^DIGITS.
REQ-022 CONV_OUT SHALL run iterative double-dabble: BIN_W cycles, add-3 correction on every digit >=5 before each shift.
REQ-023 DONE SHALL last one cycle, assert done, deassert busy at the following edge, and return to IDLE.
REQ-024 Latency: with start accepted at edge E0, done SHALL be high in the cycle after edge E0+DIGITS+BIN_W+2 (21 cycles for DIGITS=4); error paths SHALL be shorter.
REQ-025 start held high across DONE SHALL be accepted again in the IDLE cycle that follows, giving back-to-back operations.

Reset
REQ-026 rst SHALL force IDLE, busy=0, done=0, res=0, ovf=0, neg=0, err=0 and clear the internal accumulators.
REQ-027 rst asserted in any state, including mid CONV_OUT, SHALL abort the operation with no done pulse; rst has priority over start.

Configuration
REQ-028 With macro BCD_ALU_SIGN_EN defined, a subtract with num2>num1 SHALL give res=|num1-num2|, neg=1, err=0.
REQ-029 Without BCD_ALU_SIGN_EN, that case SHALL give res=0, neg=0, err=1, and neg SHALL be tied to 0.

Structure
REQ-030 Package bcd_alu_pkg SHALL hold the op encoding constants, the FSM state encoding, and the function computing BIN_W from DIGITS.
REQ-031 Binary-to-BCD conversion SHALL be one sub-module, bcd_dabble_seq, parameterised by DIGITS and BIN_W, with a load/done handshake.

Verification (DIGITS=4)
REQ-032 1234 add 4321 -> res=5555, ovf=0, err=0, done exactly 21 cycles after accept.
REQ-033 9999 add 0001 -> res=0000, ovf=1; 0000 add 0000 -> res=0000, ovf=0.
REQ-034 0005 sub 0012 -> with SIGN_EN res=0007, neg=1; without SIGN_EN res=0000, err=1.
REQ-035 num1=0x12A4 add 0001 -> err=1, res=0; op=11 -> err=1.
REQ-036 rst pulsed 5 cycles into CONV_OUT -> busy=0 next cycle, no done pulse; a following 0042 add 0058 -> res=0100.
REQ-037 start toggled while busy -> ignored, single done pulse; start held high -> back-to-back done pulses 22 cycles apart.
